// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared score-display types, staff geometry and pitch lookup constants
//
// Purpose: common definitions for the note writer and the pixel renderer.
//   note_entry_t : 16-bit glyph slot entry stored in the note buffer
//   state_t      : note writer FSM encoding (ST_BAR exists only with BAR_LINE_EN)
//   STEP_TABLE   : semitone -> diatonic step within the octave
//   SHARP_MASK   : semitone -> sharp flag
// Optional feature macro: BAR_LINE_EN
// Ports: none (package).
package score_pkg;

  localparam int NUM_STAVES      = 4;
  localparam int SLOTS_PER_STAFF = 16;
  localparam int NUM_SLOTS       = NUM_STAVES * SLOTS_PER_STAFF;
  localparam int MEASURE_UNITS   = 16;
  localparam int STAFF_REF_NOTE  = 64;

  // The reference note is an E, which is diatonic step 2 of its octave.
  localparam int STAFF_REF_POS   = (STAFF_REF_NOTE / 12) * 7 + 2;
  localparam int STAFF_POS_MIN   = -16;
  localparam int STAFF_POS_MAX   = 15;

  localparam logic [15:0] BAR_ENTRY = 16'hC000;

  // Semitone 11 in the top field, semitone 0 in the bottom field.
  localparam logic [35:0] STEP_TABLE = {3'd6, 3'd5, 3'd5, 3'd4, 3'd4, 3'd3,
                                        3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
  localparam logic [11:0] SHARP_MASK = 12'b0101_0100_1010;

  typedef struct packed {
    logic              valid;
    logic              bar;
    logic              sharp;
    logic signed [4:0] pos;
    logic [3:0]        dur;
    logic              rest;
    logic [2:0]        zero;
  } note_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_WRITE   = 3'd2,
`ifdef BAR_LINE_EN
    ST_BAR     = 3'd3,
`endif
    ST_CLEAR   = 3'd4
  } state_t;

endpackage

// File: rtl/note_to_staff.sv
// rtl/note_to_staff.sv - combinational MIDI note to treble-staff position converter
//
// Purpose: maps a MIDI note number to a signed staff position (0 = bottom line,
// +1 per line/space step), a sharp flag and a rest flag. Note 0 is a rest.
// Ports:
//   note  in  8  MIDI note number
//   pos   out 5  signed staff position, saturated to -16..+15
//   sharp out 1  accidental sharp
//   rest  out 1  note is a rest
module note_to_staff
  import score_pkg::*;
(
  input  logic [7:0]        note,
  output logic signed [4:0] pos,
  output logic              sharp,
  output logic              rest
);

  logic [4:0] octave;
  logic [3:0] semi;
  logic [5:0] step_idx;
  logic [2:0] step;
  int         raw;

  always_comb begin
    octave   = 5'(note / 8'd12);
    semi     = 4'(note % 8'd12);
    step_idx = {2'b00, semi} * 6'd3;
    step     = STEP_TABLE[step_idx +: 3];
    raw      = int'(octave) * 7 + int'(step) - STAFF_REF_POS;

    if (raw < STAFF_POS_MIN) begin
      pos = 5'(STAFF_POS_MIN);
    end else if (raw > STAFF_POS_MAX) begin
      pos = 5'(STAFF_POS_MAX);
    end else begin
      pos = raw[4:0];
    end
    sharp = SHARP_MASK[semi];
    rest  = 1'b0;

    if (note == 8'd0) begin
      pos   = 5'sd0;
      sharp = 1'b0;
      rest  = 1'b1;
    end
  end

endmodule

// File: rtl/score_note_writer.sv
// rtl/score_note_writer.sv - note event to glyph-entry writer for the 64-slot score buffer
//
// Purpose: buffers one note event, converts it to a staff glyph entry and writes
// it at the cursor; wraps into a page wipe after slot 63; optional bar lines.
// Optional feature macro: BAR_LINE_EN (measure accumulator and bar entries).
// Ports:
//   clk       in  1   system clock
//   reset     in  1   synchronous, active-low
//   note      in  8   MIDI note, 0 = rest
//   duration  in  4   sixteenth units 1..15, 0 drops the event
//   note_dec  in  1   event strobe
//   clear_req in  1   wipe page and home cursor
//   rd_addr   in  6   renderer slot address {staff, slot}
//   rd_data   out 16  slot entry, one cycle after rd_addr
//   wr_ptr    out 6   cursor
//   busy      out 1   FSM not idle
//   overflow  out 1   sticky lost-event flag
module score_note_writer
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  note,
  input  logic [3:0]  duration,
  input  logic        note_dec,
  input  logic        clear_req,
  input  logic [5:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [5:0]  wr_ptr,
  output logic        busy,
  output logic        overflow
);

  logic [15:0] mem [NUM_SLOTS];

  state_t      state, state_nx;
  logic        hold_full;
  logic [7:0]  hold_note, cur_note;
  logic [3:0]  hold_dur, cur_dur;
  note_entry_t entry_q, entry_c;
  logic [5:0]  clr_ptr;

  logic        accept, consume, ptr_inc, clr_start, clear_done;
  logic        mem_we;
  logic [5:0]  mem_wa;
  logic [15:0] mem_wd;
  logic        last_slot;

  logic signed [4:0] conv_pos;
  logic              conv_sharp, conv_rest;

`ifdef BAR_LINE_EN
  logic [4:0] acc, acc_sum;
  logic       acc_add, acc_bar;
  assign acc_sum = acc + {1'b0, entry_q.dur};
`endif

  note_to_staff u_note_to_staff (
    .note  (cur_note),
    .pos   (conv_pos),
    .sharp (conv_sharp),
    .rest  (conv_rest)
  );

  always_comb begin
    entry_c       = '0;
    entry_c.valid = 1'b1;
    entry_c.sharp = conv_sharp;
    entry_c.pos   = conv_pos;
    entry_c.dur   = cur_dur;
    entry_c.rest  = conv_rest;
  end

  assign accept    = note_dec && (duration != 4'd0);
  assign last_slot = (wr_ptr == 6'(NUM_SLOTS - 1));
  // Held low during reset; the post-reset page wipe is reported as busy.
  assign busy      = reset && (state != ST_IDLE);

  always_comb begin
    state_nx   = state;
    consume    = 1'b0;
    ptr_inc    = 1'b0;
    clr_start  = 1'b0;
    clear_done = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = wr_ptr;
    mem_wd     = entry_q;
`ifdef BAR_LINE_EN
    acc_add    = 1'b0;
    acc_bar    = 1'b0;
`endif
    if (clear_req) begin
      // Wins over any write this cycle; the holding register is left alone.
      state_nx  = ST_CLEAR;
      clr_start = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hold_full) begin
            consume  = 1'b1;
            state_nx = ST_CONVERT;
          end
        end
        ST_CONVERT: state_nx = ST_WRITE;
        ST_WRITE: begin
          mem_we  = 1'b1;
          ptr_inc = 1'b1;
`ifdef BAR_LINE_EN
          if (acc_sum >= 5'(MEASURE_UNITS)) begin
            state_nx = ST_BAR;
          end else begin
            acc_add   = 1'b1;
            state_nx  = last_slot ? ST_CLEAR : ST_IDLE;
            clr_start = last_slot;
          end
`else
          state_nx  = last_slot ? ST_CLEAR : ST_IDLE;
          clr_start = last_slot;
`endif
        end
`ifdef BAR_LINE_EN
        ST_BAR: begin
          if (wr_ptr == 6'd0) begin
            // The note filled the page; the bar would land on a wiped page.
            state_nx  = ST_CLEAR;
            clr_start = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_wd    = BAR_ENTRY;
            ptr_inc   = 1'b1;
            acc_bar   = 1'b1;
            state_nx  = last_slot ? ST_CLEAR : ST_IDLE;
            clr_start = last_slot;
          end
        end
`endif
        ST_CLEAR: begin
          mem_we = 1'b1;
          mem_wa = clr_ptr;
          mem_wd = '0;
          if (clr_ptr == 6'(NUM_SLOTS - 1)) begin
            clear_done = 1'b1;
            state_nx   = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      wr_ptr    <= '0;
      clr_ptr   <= '0;
      hold_full <= 1'b0;
      hold_note <= '0;
      hold_dur  <= '0;
      cur_note  <= '0;
      cur_dur   <= '0;
      entry_q   <= '0;
      overflow  <= 1'b0;
      rd_data   <= '0;
`ifdef BAR_LINE_EN
      acc       <= '0;
`endif
    end else begin
      state   <= state_nx;
      rd_data <= mem[rd_addr];

      if (clear_done) begin
        wr_ptr <= '0;
      end else if (ptr_inc) begin
        wr_ptr <= wr_ptr + 6'd1;
      end

      if (clr_start) begin
        clr_ptr <= '0;
      end else if (state == ST_CLEAR) begin
        clr_ptr <= clr_ptr + 6'd1;
      end

      // A slot freed by this edge's consume can take a new event at once.
      if (accept) begin
        if (!hold_full || consume) begin
          hold_full <= 1'b1;
          hold_note <= note;
          hold_dur  <= duration;
        end else begin
          overflow <= 1'b1;
        end
      end else if (consume) begin
        hold_full <= 1'b0;
      end

      if (consume) begin
        cur_note <= hold_note;
        cur_dur  <= hold_dur;
      end

      if (state == ST_CONVERT) begin
        entry_q <= entry_c;
      end

`ifdef BAR_LINE_EN
      if (clear_done) begin
        acc <= '0;
      end else if (acc_bar) begin
        acc <= acc_sum - 5'(MEASURE_UNITS);
      end else if (acc_add) begin
        acc <= acc_sum;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

endmodule

// File: tb/tb_score_note_writer.sv
// tb/tb_score_note_writer.sv - scoreboard bench for score_note_writer
module tb_score_note_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  note = '0;
  logic [3:0]  duration = '0;
  logic        note_dec = 1'b0;
  logic        clear_req = 1'b0;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [5:0]  wr_ptr;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [5:0]  slot_q[$];
  logic [5:0]  prev_ptr = '0;
  logic [5:0]  mon_addr = '0;
  logic        mon_pending = 1'b0;
  logic [5:0]  scan_addr = '0;
  int          exp_ptr = 0;
  int          exp_acc = 0;

`ifdef BAR_LINE_EN
  localparam int BAR_TEST_PTR = 3;
  localparam int FILL_SENDS   = 61;
`else
  localparam int BAR_TEST_PTR = 2;
  localparam int FILL_SENDS   = 64;
`endif

  logic [7:0]  fill_note [4] = '{8'd64, 8'd61, 8'd0, 8'd120};
  logic [15:0] fill_ent  [4] = '{16'h8010, 16'hBE10, 16'h8018, 16'h8F10};

  assign rd_addr = mon_pending ? mon_addr : scan_addr;

  always #5 clk = ~clk;

  score_note_writer dut (
    .clk       (clk),
    .reset     (reset),
    .note      (note),
    .duration  (duration),
    .note_dec  (note_dec),
    .clear_req (clear_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_ptr    (wr_ptr),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every slot write advances wr_ptr by one; read that slot back and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_pending) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {16'h0, rd_data}, 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("slot%0d", mon_addr), {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
        end
      end
      if (reset && (wr_ptr == prev_ptr + 6'd1)) slot_q.push_back(prev_ptr);
      prev_ptr = wr_ptr;
      if (slot_q.size() > 0) begin
        mon_addr    = slot_q.pop_front();
        mon_pending = 1'b1;
      end else begin
        mon_pending = 1'b0;
      end
    end
  end

  task automatic expect_note(input logic [15:0] e, input int d);
    exp_q.push_back(e);
    exp_ptr = (exp_ptr + 1) % 64;
    exp_acc += d;
`ifdef BAR_LINE_EN
    if (exp_acc >= 16) begin
      if (exp_ptr != 0) begin
        exp_q.push_back(16'hC000);
        exp_ptr = (exp_ptr + 1) % 64;
        exp_acc -= 16;
      end
    end
`endif
    if (exp_ptr == 0) exp_acc = 0;
  endtask

  task automatic strobe(input logic [7:0] n, input logic [3:0] d);
    @(negedge clk);
    note = n; duration = d; note_dec = 1'b1;
    @(negedge clk);
    note_dec = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles);
    int idle = 0;
    int n = 0;
    busy_cycles = 0;
    while (idle < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (busy) begin busy_cycles++; idle = 0; end
      else idle++;
    end
    if (n >= 400) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic send(input logic [7:0] n, input logic [3:0] d, input logic [15:0] e);
    int bc;
    expect_note(e, int'(d));
    strobe(n, d);
    wait_idle(bc);
  endtask

  task automatic fresh_page();
    int bc;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_idle(bc);
    exp_ptr = 0;
    exp_acc = 0;
    chk("fresh_wr_ptr", 32'(wr_ptr), 32'd0);
  endtask

  task automatic scan_zero(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      scan_addr = 6'(i);
      @(negedge clk);
      chk($sformatf("wiped%0d", i), {16'h0, rd_data}, 32'h0);
    end
  endtask

  initial begin
    int cnt, n, bc, sends;

    repeat (3) @(negedge clk);
    chk("rst_rd_data", {16'h0, rd_data}, 32'h0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    #1;
    cnt = 0; n = 0;
    while (busy && n < 200) begin
      cnt++;
      @(negedge clk);
      n++;
    end
    chk("reset_clear_cycles", 32'(cnt), 32'd64);

    // Pitch conversion, sharp and rest.
    send(8'd64, 4'd4, 16'h8040);
    chk("wr_ptr_after_first", 32'(wr_ptr), 32'd1);
    send(8'd61, 4'd2, 16'hBE20);
    send(8'd0,  4'd8, 16'h8088);
    chk("wr_ptr_three", 32'(wr_ptr), 32'd3);

    // Measure boundary: two half notes.
    fresh_page();
    send(8'd65, 4'd8, 16'h8180);
    send(8'd67, 4'd8, 16'h8280);
    chk("bar_wr_ptr", 32'(wr_ptr), 32'(BAR_TEST_PTR));

    // Staff position saturation.
    send(8'd20,  4'd1, 16'hB010);
    send(8'd120, 4'd1, 16'h8F10);

    // Zero duration is dropped silently.
    strobe(8'd64, 4'd0);
    wait_idle(bc);
    chk("zero_dur_wr_ptr", 32'(wr_ptr), 32'(exp_ptr));

    // Three back-to-back events: third finds the holding register full.
    chk("overflow_clear", 32'(overflow), 32'd0);
    expect_note(16'h9F30, 3);
    expect_note(16'h8550, 5);
    @(negedge clk);
    note = 8'd62; duration = 4'd3; note_dec = 1'b1;
    @(negedge clk);
    note = 8'd72; duration = 4'd5;
    @(negedge clk);
    note = 8'd74; duration = 4'd1;
    @(negedge clk);
    note_dec = 1'b0;
    wait_idle(bc);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("overflow_wr_ptr", 32'(wr_ptr), 32'(exp_ptr));

    // clear_req on the WRITE edge of the second event.
    fresh_page();
    send(8'd64, 4'd4, 16'h8040);
    strobe(8'd65, 4'd2);
    @(negedge clk);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("midwrite_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("midwrite_busy", 32'(busy), 32'd1);
    wait_idle(bc);
    exp_ptr = 0;
    exp_acc = 0;
    chk("midwrite_home", 32'(wr_ptr), 32'd0);
    scan_zero(0, 1);

    // Fill the page until the cursor wraps into the automatic wipe.
    fresh_page();
    sends = 0;
    bc = 0;
    do begin
      expect_note(fill_ent[sends % 4], 1);
      strobe(fill_note[sends % 4], 4'd1);
      wait_idle(bc);
      sends++;
    end while (exp_ptr != 0 && sends < 100);
    chk("fill_sends", 32'(sends), 32'(FILL_SENDS));
    chk("wrap_busy_cycles", 32'(bc), 32'd66);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd0);
    scan_zero(0, 63);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_note_writer.md
Name: score_note_writer

Overview:
- Producer side of the score display path. Accepts detected-note events (note, duration, note_dec strobe) and converts each to a treble-staff glyph entry.
- Writes entries sequentially into a 64-slot note buffer, arranged as 4 staves x 16 slots. The pixel renderer reads the buffer through a registered read port.
- Optionally inserts bar-line entries at 4/4 measure boundaries.
- Owns cursor, wrap and page-clear management.

Parameters:
- NUM_STAVES, 4, staves per page.
- SLOTS_PER_STAFF, 16, glyph slots per staff.
- MEASURE_UNITS, 16, sixteenth-note units per measure (4/4).
- STAFF_REF_NOTE, 64, MIDI note on the bottom staff line (E4).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- note  in  8  MIDI note number; 0 = rest
- duration  in  4  length in sixteenth units, 1..15; 0 = invalid, event dropped
- note_dec  in  1  one-cycle strobe, note/duration valid
- clear_req  in  1  one-cycle strobe, wipe page and home cursor
- rd_addr  in  6  renderer slot address, {staff[1:0], slot[3:0]}
- rd_data  out  16  slot entry, 1-cycle registered latency
- wr_ptr  out  6  next slot to be written (cursor)
- busy  out  1  FSM not in IDLE
- overflow  out  1  sticky: event lost because the holding register was full

Behaviour:
- Reset (reset==0 at clk edge):
  - rd_data=0, wr_ptr=0, busy=0, overflow=0.
  - Holding register empty, measure accumulator=0, FSM=CLEAR. Buffer contents are wiped by CLEAR, so busy=1 for 64 cycles after reset release.
- Entry format:
  - [15] valid, [14] bar, [13] sharp, [12:8] signed staff position, [7:4] duration, [3] rest, [2:0] zero.
  - Staff position 0 = bottom line; +1 per line/space step.
- Pitch conversion (combinational):
  - octave=note/12, semi=note%12.
  - Step table C0 C#0s D1 D#1s E2 F3 F#3s G4 G#4s A5 A#5s B6 (s = sharp flag set).
  - pos = octave*7 + step - 37, saturated to -16..+15.
  - Rest: pos=0, sharp=0, rest=1.
- Holding register (1 deep):
  - note_dec with duration!=0 loads it when empty.
  - If it is already full, the event is dropped and overflow is set; overflow clears only on reset.
  - When the register is consumed on the same edge a new strobe arrives, it is reloaded with the new event.
- FSM:
  - IDLE -> CONVERT when the holding register is full; the register is consumed on this edge.
  - CONVERT -> WRITE: entry registered.
  - WRITE: mem[wr_ptr]=entry, wr_ptr+1. Next state:
    - BAR if BAR_LINE_EN and acc+dur >= MEASURE_UNITS.
    - CLEAR if wr_ptr was 63.
    - IDLE otherwise.
  - BAR:
    - If the note write wrapped (wr_ptr now 0), go to CLEAR and discard the bar entry.
    - Else write {valid,bar} to mem[wr_ptr], wr_ptr+1, acc = acc+dur-MEASURE_UNITS; then CLEAR if wr_ptr was 63, else IDLE.
  - CLEAR: writes 0 to one slot per cycle, 0..63. After slot 63: wr_ptr=0, acc=0, go IDLE.
- clear_req:
  - Honoured in any state; it has priority over note/bar writes in the same cycle.
  - Enters CLEAR from slot 0 and discards any in-flight CONVERT entry.
  - The holding register is preserved.
- Accumulator without a bar write: acc = acc+dur.
- Latency: note_dec sampled at edge t with FSM idle -> buffer write at edge t+3. rd_addr==that slot returns the entry on rd_data from edge t+4.
- Read port: rd_data <= mem[rd_addr] every cycle. No write-first bypass; a same-cycle read returns old data.

Optional Feature:
- Macro BAR_LINE_EN.
- Defined: measure accumulator and BAR state are present; bar entries are inserted as above.
- Undefined: no accumulator, no BAR state; WRITE goes directly to CLEAR or IDLE, and bit [14] is never set.

Decomposition:
- Package score_pkg:
  - note-entry struct typedef.
  - FSM state enum.
  - NUM_STAVES/SLOTS_PER_STAFF defaults.
  - Step/sharp lookup constants.
  - The staff-geometry constants shared with the renderer.
- Sub-module note_to_staff: combinational MIDI -> {pos, sharp, rest}.

Test Plan:
- Reset, wait 64 cycles, then note_dec note=64 dur=4 -> mem[0]=16'h8040 (pos 0), wr_ptr=1, rd_data at slot 0 valid at t+4.
- note=61 dur=2 -> entry sharp=1, pos=-2 (C#4); note=0 dur=8 -> rest=1, pos=0.
- BAR_LINE_EN: notes dur 8, 8 -> slots 0, 1 notes; slot 2 = 16'hC000; wr_ptr=3; acc=0.
- Three note_dec strobes on consecutive cycles while busy -> two written, overflow=1.
- Fill 64 slots -> CLEAR runs, busy 64 cycles, all rd_data=0, wr_ptr=0; clear_req mid-WRITE -> CLEAR wins, slot unwritten.
- note=20 and note=120 -> pos saturates to -16 and +15.
